bcd_step_counter: RTL and testbench

- Upstream stage that generates the 4-bit BCD digit (A,B,C,D) consumed by the board's BCD next-state / seven-segment decode logic.
- Takes a raw, bouncy push-button and a direction switch, synchronises and debounces the button, and steps a decade counter (0..9) once per clean press.
- Optionally free-runs from a prescaled tick for hands-off demo.
- Sits between board I/O pins and the combinational decoder; all outputs are registered.

---
 rtl/bcd_step_counter.sv | 145 ++++++++++++++
 tb/tb_bcd_step_counter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_step_counter.sv
// Button-driven BCD decade counter: two-flop synchroniser, counter debouncer, and up/down 0..9 stepping.
// Optional free-running auto-step prescaler is compiled in with `define BCD_AUTO_STEP_EN.
module bcd_step_counter #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TICK_DIV        = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    input  logic dir,
    input  logic auto_en,
    output logic A,
    output logic B,
    output logic C,
    output logic D,
    output logic carry,
    output logic step
);

    localparam int unsigned     DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]      BCD_MAX = 4'd9;

    logic            s1;
    logic            s2;
    logic [1:0]      sync_fill;
    logic            stable;
    logic            stable_d;
    logic [DB_W-1:0] db_cnt;
    logic            armed;
    logic            press;
    logic            tick;
    logic            step_req;
    logic [3:0]      count;
    logic [3:0]      count_nxt;
    logic            wrap;

    // sync_fill marks when s2 holds a genuinely sampled btn value after reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            sync_fill <= 2'b00;
        end else begin
            s1        <= btn;
            s2        <= s1;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    // Debounce: accept a new level only after it persists for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stable <= 1'b0;
            db_cnt <= '0;
        end else if (s2 == stable) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            stable <= s2;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    // A press held through reset must be released before presses are honoured again
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stable_d <= 1'b0;
            armed    <= 1'b0;
            press    <= 1'b0;
        end else begin
            stable_d <= stable;
            if (sync_fill[1] && !s2) begin
                armed <= 1'b1;
            end
            press <= armed && stable && !stable_d;
        end
    end

`ifdef BCD_AUTO_STEP_EN
    localparam int unsigned     PS_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    logic [PS_W-1:0] presc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (!auto_en || presc == PS_LAST) begin
            presc <= '0;
        end else begin
            presc <= presc + PS_W'(1);
        end
    end

    assign tick = auto_en && (presc == PS_LAST);
`else
    localparam int unsigned unused_tick_div = TICK_DIV;
    logic unused_auto_en;

    assign unused_auto_en = auto_en;
    assign tick           = 1'b0;
`endif

    // Press and tick in the same cycle collapse into a single step
    assign step_req = press | tick;

    always_comb begin
        count_nxt = count;
        wrap      = 1'b0;
        if (dir) begin
            if (count == 4'd0) begin
                count_nxt = BCD_MAX;
                wrap      = 1'b1;
            end else begin
                count_nxt = count - 4'd1;
            end
        end else begin
            if (count >= BCD_MAX) begin
                count_nxt = 4'd0;
                wrap      = 1'b1;
            end else begin
                count_nxt = count + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= 4'd0;
            carry <= 1'b0;
            step  <= 1'b0;
        end else begin
            step  <= step_req;
            carry <= step_req && wrap;
            if (step_req) begin
                count <= count_nxt;
            end
        end
    end

    assign {A, B, C, D} = count;

endmodule

// File: tb/tb_bcd_step_counter.sv
// Self-checking bench for bcd_step_counter: randomised bouncy presses checked against an event-level decade model.
module tb_bcd_step_counter;

    localparam int unsigned DEB  = 4;
    localparam int unsigned TDIV = 12;
    localparam int          LAT  = DEB + 3;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic btn     = 1'b0;
    logic dir     = 1'b0;
    logic auto_en = 1'b0;
    logic A, B, C, D, carry, step;

    typedef struct packed {
        logic [3:0] cnt;
        logic       stp;
        logic       cry;
    } samp_t;

    samp_t obs[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    m_count  = 0;

    bcd_step_counter #(.DEBOUNCE_CYCLES(DEB), .TICK_DIV(TDIV)) dut (
        .clk(clk), .rst_n(rst_n), .btn(btn), .dir(dir), .auto_en(auto_en),
        .A(A), .B(B), .C(C), .D(D), .carry(carry), .step(step)
    );

    always #5 clk = ~clk;

    // Decade model: advance by one in the chosen direction, report wrap
    function automatic bit model_step(input bit down);
        bit w;
        w       = down ? (m_count == 0) : (m_count == 9);
        m_count = (m_count + (down ? 9 : 1)) % 10;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit b);
        samp_t s;
        btn = b;
        tick();
        s = {A, B, C, D, step, carry};
        obs.push_back(s);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; btn = 1'b0; auto_en = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        repeat (6) tick();
        m_count = 0;
    endtask

    // Bounce runs shorter than DEB, then steady high, then a long low
    task automatic press(input int nglitch, input int hold, input int low, output int step_at);
        obs.delete();
        for (int g = 0; g < nglitch; g++) begin
            repeat ($urandom_range(DEB - 1, 1)) drive(1'b1);
            repeat ($urandom_range(DEB - 1, 1)) drive(1'b0);
        end
        step_at = obs.size() + LAT;
        repeat (hold) drive(1'b1);
        repeat (low) drive(1'b0);
    endtask

    task automatic test_reset();
        samp_t s;
        rst_n = 1'b0; btn = 1'b0; auto_en = 1'b0;
        for (int k = 0; k < 52; k++) begin
            if (k == 2) rst_n = 1'b1;
            tick();
            s = {A, B, C, D, step, carry};
            n_checks++;
            if (s !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_idle k=%0d got %b want 000000", k, s);
            end
        end
        m_count = 0;
    endtask

    task automatic test_clean_press();
        int sa;
        samp_t exp;
        bit es, ec;
        dir = 1'b0;
        press(0, 20, DEB + 8, sa);
        for (int i = 0; i < obs.size(); i++) begin
            es  = (i == sa);
            ec  = es ? model_step(1'b0) : 1'b0;
            exp = {4'(m_count), es, ec};
            n_checks++;
            if (obs[i] !== exp) begin
                n_fail++;
                $display("FAIL clean_press i=%0d got %b want %b", i, obs[i], exp);
            end
        end
    endtask

    task automatic test_bounce();
        int sa;
        samp_t exp;
        bit es, ec;
        dir = 1'b0;
        obs.delete();
        repeat (2) begin
            repeat (2) drive(1'b1);
            repeat (2) drive(1'b0);
        end
        sa = obs.size() + LAT;
        repeat (12) drive(1'b1);
        repeat (3) drive(1'b0);
        repeat (10) drive(1'b1);
        repeat (DEB + 8) drive(1'b0);
        for (int i = 0; i < obs.size(); i++) begin
            es  = (i == sa);
            ec  = es ? model_step(1'b0) : 1'b0;
            exp = {4'(m_count), es, ec};
            n_checks++;
            if (obs[i] !== exp) begin
                n_fail++;
                $display("FAIL bounce i=%0d got %b want %b", i, obs[i], exp);
            end
        end
    endtask

    task automatic test_wrap();
        int sa;
        samp_t exp;
        bit es, ec;
        do_reset();
        for (int p = 0; p < 12; p++) begin
            dir = (p >= 10);
            press(int'($urandom_range(2, 0)), DEB + 2, DEB + 6, sa);
            for (int i = 0; i < obs.size(); i++) begin
                es  = (i == sa);
                ec  = es ? model_step(dir) : 1'b0;
                exp = {4'(m_count), es, ec};
                n_checks++;
                if (obs[i] !== exp) begin
                    n_fail++;
                    $display("FAIL wrap p=%0d i=%0d got %b want %b", p, i, obs[i], exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int sa;
        samp_t s, exp;
        bit es, ec;
        do_reset();
        dir = 1'b0;
        repeat (5) begin
            press(0, DEB + 2, DEB + 6, sa);
            ec = model_step(1'b0);
        end
        btn = 1'b1;
        repeat (4) tick();
        s = {A, B, C, D, step, carry};
        n_checks++;
        if (s !== {4'(m_count), 2'b00}) begin
            n_fail++;
            $display("FAIL mid_before got %b want %b", s, {4'(m_count), 2'b00});
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_count = 0;
        s = {A, B, C, D, step, carry};
        n_checks++;
        if (s !== 6'b0) begin
            n_fail++;
            $display("FAIL mid_reset got %b want 000000", s);
        end
        obs.delete();
        repeat (30) drive(1'b1);
        repeat (DEB + 8) drive(1'b0);
        for (int i = 0; i < obs.size(); i++) begin
            n_checks++;
            if (obs[i] !== 6'b0) begin
                n_fail++;
                $display("FAIL held_through_reset i=%0d got %b want 000000", i, obs[i]);
            end
        end
        press(1, DEB + 3, DEB + 6, sa);
        for (int i = 0; i < obs.size(); i++) begin
            es  = (i == sa);
            ec  = es ? model_step(1'b0) : 1'b0;
            exp = {4'(m_count), es, ec};
            n_checks++;
            if (obs[i] !== exp) begin
                n_fail++;
                $display("FAIL repress i=%0d got %b want %b", i, obs[i], exp);
            end
        end
    endtask

    task automatic test_random();
        int sa;
        samp_t exp;
        bit es, ec, d;
        for (int p = 0; p < 16; p++) begin
            d   = 1'($urandom_range(1, 0));
            dir = d;
            press(int'($urandom_range(3, 0)), int'($urandom_range(16, DEB + 1)),
                  int'($urandom_range(DEB + 12, DEB + 6)), sa);
            for (int i = 0; i < obs.size(); i++) begin
                es  = (i == sa);
                ec  = es ? model_step(d) : 1'b0;
                exp = {4'(m_count), es, ec};
                n_checks++;
                if (obs[i] !== exp) begin
                    n_fail++;
                    $display("FAIL random p=%0d i=%0d got %b want %b", p, i, obs[i], exp);
                end
            end
        end
    endtask

`ifdef BCD_AUTO_STEP_EN
    // Ticks every TDIV cycles; one press lands on a tick, one between ticks
    task automatic test_auto();
        samp_t s, exp;
        bit es, ec;
        do_reset();
        dir = 1'b0;
        for (int k = 1; k <= 190; k++) begin
            auto_en = (k <= 160);
            btn     = (k >= 125 && k < 135) || (k >= 143 && k < 153);
            tick();
            es  = (k <= 160) && ((k % TDIV == 0) || (k == 150));
            ec  = es ? model_step(1'b0) : 1'b0;
            exp = {4'(m_count), es, ec};
            s   = {A, B, C, D, step, carry};
            n_checks++;
            if (s !== exp) begin
                n_fail++;
                $display("FAIL auto k=%0d got %b want %b", k, s, exp);
            end
        end
        btn = 1'b0;
    endtask
`else
    task automatic test_auto();
        samp_t s;
        auto_en = 1'b1;
        for (int k = 0; k < 60; k++) begin
            tick();
            s = {A, B, C, D, step, carry};
            n_checks++;
            if (s !== {4'(m_count), 2'b00}) begin
                n_fail++;
                $display("FAIL auto_ignored k=%0d got %b want %b", k, s, {4'(m_count), 2'b00});
            end
        end
        auto_en = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_wrap();
        test_reset_mid();
        test_random();
        test_auto();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
